// File: rtl/route_pkg.sv
// Shared definitions for the route sequencer: FSM states, step codes,
// car_state codes and the car mode that enables sequencing.
package route_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_XR,
        ISSUE,
        TRAVEL,
        DONE,
        FAULT
    } state_t;

    localparam logic [1:0] STEP_STRAIGHT = 2'b00;
    localparam logic [1:0] STEP_LEFT     = 2'b01;
    localparam logic [1:0] STEP_RIGHT    = 2'b10;
    localparam logic [1:0] STEP_BACK     = 2'b11;

    localparam logic [1:0] CAR_FORWARD   = 2'b00;
    localparam logic [1:0] CAR_CROSSROAD = 2'b01;
    localparam logic [1:0] CAR_TURNING   = 2'b10;
    localparam logic [1:0] CAR_COOLDOWN  = 2'b11;

    localparam logic [1:0] MODE_ENABLED  = 2'b10;

    // One-hot command vector ordered {back, right, left, straight}.
    function automatic logic [3:0] decode_step(input logic [1:0] code);
        logic [3:0] onehot;
        onehot = 4'b0000;
        case (code)
            STEP_STRAIGHT: onehot = 4'b0001;
            STEP_LEFT:     onehot = 4'b0010;
            STEP_RIGHT:    onehot = 4'b0100;
            STEP_BACK:     onehot = 4'b1000;
            default:       onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/route_mem.sv
// DEPTH x 2-bit route step storage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module route_mem #(
    parameter int DEPTH = 8
) (
    input  logic       sys_clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [1:0] wdata,
    input  logic [3:0] raddr,
    output logic [1:0] rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (waddr == 4'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    // Addresses past the array read as zero instead of indexing out of range.
    always_comb begin
        rdata = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == 4'(i)) begin
                rdata = mem[i];
            end
        end
    end

endmodule

// File: rtl/route_sequencer.sv
// Route sequencer: stores a list of turn steps and hands them one at a time
// to the driving FSM at each crossroad. Define ROUTE_LOOP_EN to replay forever.
module route_sequencer
    import route_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] car_state,
    input  logic       load_valid,
    input  logic [1:0] load_cmd,
    output logic       load_ready,
    input  logic       start,
    input  logic       clear,
    output logic       straight,
    output logic       left,
    output logic       right,
    output logic       back,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] count,
    output logic [3:0] step_idx
);

    state_t      state, next_state;
    logic [1:0]  cmd_reg;
    logic [1:0]  mem_rdata;
    logic [3:0]  cmd_out;
    logic [31:0] timer;
    logic        enable;
    logic        load_fire;

    assign enable     = power && (global_state == MODE_ENABLED);
    assign load_ready = (state == IDLE) && (count < 4'(DEPTH));
    assign load_fire  = load_valid && load_ready && !clear;

    route_mem #(.DEPTH(DEPTH)) u_mem (
        .sys_clk (sys_clk),
        .we      (load_fire),
        .waddr   (count),
        .wdata   (load_cmd),
        .raddr   (step_idx),
        .rdata   (mem_rdata)
    );

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else if ((state != IDLE) && !enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && (count != 4'd0) && enable) next_state = WAIT_XR;
                WAIT_XR: if (car_state == CAR_CROSSROAD) next_state = ISSUE;
                ISSUE: begin
                    if (car_state != CAR_CROSSROAD)      next_state = TRAVEL;
                    else if (timer == TIMEOUT - 32'd1)   next_state = FAULT;
                end
                TRAVEL: begin
                    if (car_state == CAR_FORWARD) begin
`ifdef ROUTE_LOOP_EN
                        next_state = WAIT_XR;
`else
                        next_state = (step_idx == count) ? DONE : WAIT_XR;
`endif
                    end
                end
                DONE:    if (start) next_state = WAIT_XR;
                FAULT:   next_state = FAULT;
                default: next_state = IDLE;
            endcase
        end
    end

    // Command outputs lag ISSUE entry by one cycle and drop on the edge that leaves ISSUE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            step_idx <= 4'd0;
            timer    <= 32'd0;
            cmd_reg  <= 2'b00;
            cmd_out  <= 4'b0000;
        end else begin
            state   <= next_state;
            cmd_out <= ((state == ISSUE) && (next_state == ISSUE)) ? decode_step(cmd_reg) : 4'b0000;
            timer   <= ((state == ISSUE) && (next_state == ISSUE)) ? timer + 32'd1 : 32'd0;

            if (clear)          count <= 4'd0;
            else if (load_fire) count <= count + 4'd1;

            if (next_state == IDLE)
                step_idx <= 4'd0;
            else if ((next_state == WAIT_XR) && ((state == IDLE) || (state == DONE)))
                step_idx <= 4'd0;
            else if ((state == TRAVEL) && (next_state == WAIT_XR) && (step_idx == count))
                step_idx <= 4'd0;
            else if ((state == ISSUE) && (next_state == TRAVEL))
                step_idx <= step_idx + 4'd1;

            if ((state == WAIT_XR) && (next_state == ISSUE))
                cmd_reg <= mem_rdata;
        end
    end

    assign {back, right, left, straight} = cmd_out;
    assign busy  = (state == WAIT_XR) || (state == ISSUE) || (state == TRAVEL);
    assign done  = (state == DONE);
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_route_sequencer.sv
// Directed self-checking bench for route_sequencer (TIMEOUT shortened to 10).
// Build with ROUTE_LOOP_EN defined to exercise the endless-loop variant.
module tb_route_sequencer;

    logic       sys_clk;
    logic       rst;
    logic       power;
    logic [1:0] global_state;
    logic [1:0] car_state;
    logic       load_valid;
    logic [1:0] load_cmd;
    logic       load_ready;
    logic       start;
    logic       clear;
    logic       straight, left, right, back;
    logic       busy, done, fault;
    logic [3:0] count;
    logic [3:0] step_idx;
    logic [3:0] cmds;

    int checks;
    int failures;

    assign cmds = {back, right, left, straight};

    route_sequencer #(.DEPTH(8), .TIMEOUT(32'd10)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .power        (power),
        .global_state (global_state),
        .car_state    (car_state),
        .load_valid   (load_valid),
        .load_cmd     (load_cmd),
        .load_ready   (load_ready),
        .start        (start),
        .clear        (clear),
        .straight     (straight),
        .left         (left),
        .right        (right),
        .back         (back),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .count        (count),
        .step_idx     (step_idx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic load_step(input logic [1:0] code);
        load_valid = 1'b1;
        load_cmd   = code;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_load_ready actual=%b required=1", load_ready); end
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count actual=%0d required=0", count); end
        checks++; if (step_idx !== 4'd0) begin failures++; $display("[TB] FAIL reset_step_idx actual=%0d required=0", step_idx); end
        checks++; if ({busy, done, fault, cmds} !== 7'b0) begin failures++; $display("[TB] FAIL reset_outputs actual=%b required=0000000", {busy, done, fault, cmds}); end
    endtask

    task automatic test_start_empty();
        pulse_start();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL start_empty_busy actual=%b required=0", busy); end
    endtask

    task automatic test_route();
        logic [3:0] expected [3];
        expected[0] = 4'b0010;
        expected[1] = 4'b0100;
        expected[2] = 4'b0001;
        load_step(2'b01);
        load_step(2'b10);
        load_step(2'b00);
        checks++; if (count !== 4'd3) begin failures++; $display("[TB] FAIL route_loaded_count actual=%0d required=3", count); end
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL route_start_busy actual=%b required=1", busy); end
        for (int k = 0; k < 3; k++) begin
            car_state = 2'b01;
            tick();
            checks++; if (cmds !== 4'b0000) begin failures++; $display("[TB] FAIL route_issue_latency step=%0d actual=%b required=0000", k, cmds); end
            tick();
            checks++; if (cmds !== expected[k]) begin failures++; $display("[TB] FAIL route_cmd step=%0d actual=%b required=%b", k, cmds, expected[k]); end
            car_state = 2'b10;
            tick();
            checks++; if (cmds !== 4'b0000) begin failures++; $display("[TB] FAIL route_travel_cmd step=%0d actual=%b required=0000", k, cmds); end
            checks++; if (step_idx !== 4'(k + 1)) begin failures++; $display("[TB] FAIL route_step_idx step=%0d actual=%0d required=%0d", k, step_idx, k + 1); end
            car_state = 2'b11;
            tick();
            car_state = 2'b00;
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL route_done actual=%b required=1", done); end
        checks++; if (count !== 4'd3) begin failures++; $display("[TB] FAIL route_final_count actual=%0d required=3", count); end
    endtask

    task automatic test_clear_start_done();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("[TB] FAIL clear_start_state actual=%b required=00", {busy, done}); end
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL clear_start_count actual=%0d required=0", count); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL clear_start_load_ready actual=%b required=1", load_ready); end
    endtask

    task automatic test_loop();
        load_step(2'b01);
        load_step(2'b10);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            car_state = 2'b01;
            tick();
            tick();
            checks++; if (cmds !== ((k == 0) ? 4'b0010 : 4'b0100)) begin failures++; $display("[TB] FAIL loop_cmd step=%0d actual=%b", k, cmds); end
            car_state = 2'b10;
            tick();
            car_state = 2'b11;
            tick();
            car_state = 2'b00;
            tick();
        end
        checks++; if (step_idx !== 4'd0) begin failures++; $display("[TB] FAIL loop_step_idx actual=%0d required=0", step_idx); end
        checks++; if ({busy, done} !== 2'b10) begin failures++; $display("[TB] FAIL loop_state actual=%b required=10", {busy, done}); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_depth_full();
        for (int i = 0; i < 8; i++) begin
            load_step(2'(i));
        end
        checks++; if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_count actual=%0d required=8", count); end
        checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_load_ready actual=%b required=0", load_ready); end
        load_step(2'b11);
        checks++; if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_ninth_count actual=%0d required=8", count); end
    endtask

    task automatic test_timeout();
        car_state = 2'b00;
        pulse_start();
        car_state = 2'b01;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early_fault actual=%b required=0", fault); end
        checks++; if (cmds !== 4'b0001) begin failures++; $display("[TB] FAIL timeout_cmd actual=%b required=0001", cmds); end
        tick();
        checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL timeout_fault actual=%b required=1", fault); end
        checks++; if (cmds !== 4'b0000) begin failures++; $display("[TB] FAIL timeout_cmd_off actual=%b required=0000", cmds); end
        car_state = 2'b00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if ({fault, busy} !== 2'b00) begin failures++; $display("[TB] FAIL timeout_clear_state actual=%b required=00", {fault, busy}); end
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL timeout_clear_count actual=%0d required=0", count); end
    endtask

    task automatic test_power_drop();
        load_step(2'b01);
        load_step(2'b10);
        pulse_start();
        car_state = 2'b01;
        tick();
        tick();
        checks++; if (cmds !== 4'b0010) begin failures++; $display("[TB] FAIL power_pre_cmd actual=%b required=0010", cmds); end
        power = 1'b0;
        tick();
        checks++; if ({busy, cmds} !== 5'b0) begin failures++; $display("[TB] FAIL power_drop_outputs actual=%b required=00000", {busy, cmds}); end
        checks++; if (count !== 4'd2) begin failures++; $display("[TB] FAIL power_drop_count actual=%0d required=2", count); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL power_drop_idle actual=%b required=1", load_ready); end
        power = 1'b1;
        car_state = 2'b00;
        pulse_start();
        checks++; if ({busy, step_idx} !== 5'b1_0000) begin failures++; $display("[TB] FAIL power_restart actual=%b required=10000", {busy, step_idx}); end
        car_state = 2'b01;
        tick();
        tick();
        checks++; if (cmds !== 4'b0010) begin failures++; $display("[TB] FAIL power_replay_cmd actual=%b required=0010", cmds); end
    endtask

    task automatic test_reset_midroute();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        car_state = 2'b00;
        checks++; if ({busy, cmds} !== 5'b0) begin failures++; $display("[TB] FAIL midroute_reset_outputs actual=%b required=00000", {busy, cmds}); end
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL midroute_reset_count actual=%0d required=0", count); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        power        = 1'b1;
        global_state = 2'b10;
        car_state    = 2'b00;
        load_valid   = 1'b0;
        load_cmd     = 2'b00;
        start        = 1'b0;
        clear        = 1'b0;
        tick();
        test_reset();
        test_start_empty();
`ifdef ROUTE_LOOP_EN
        test_loop();
`else
        test_route();
        test_clear_start_done();
`endif
        test_depth_full();
        test_timeout();
        test_power_drop();
        test_reset_midroute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
